// File: rtl/dff_pipeline.sv
// Multi-stage valid/ready register pipeline with bubble collapse,
// synchronous flush and a fixed reset value for every data register.
module dff_pipeline #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  // Running scalar avoids a self-referencing vector in the chain.
  always_comb begin
    logic a;
    adv = '0;
    a = !v_q[DEPTH-1] || out_ready;
    adv[DEPTH-1] = a;
    for (int i = DEPTH-2; i >= 0; i--) begin
      a = !v_q[i] || a;
      adv[i] = a;
    end
  end

  assign in_ready = adv[0] && !flush;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (adv[0]) begin
        v_d[0] = in_valid;
        if (in_valid)
          d_d[0] = in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1])
            d_d[i] = d_q[i-1];
        end
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + CW'(v_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        d_q[i] <= RESET_VAL;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        d_q[i] <= d_d[i];
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = cnt_q;

endmodule

// File: tb/tb_dff_pipeline.sv
// Randomised and directed bench for dff_pipeline against a
// word/position queue model of the pipeline.
module tb_dff_pipeline;

  localparam int         W  = 8;
  localparam int         D  = 4;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] data;
    int         pos;
  } ent_t;

  ent_t       q[$];
  logic [7:0] last_d = RV;

  always #5 clk = ~clk;

  dff_pipeline #(
    .WIDTH(W),
    .DEPTH(D),
    .RESET_VAL(RV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // One clock: drive at negedge, check, then advance the model.
  task automatic step(input logic r, input logic fl,
                      input logic iv, input logic [7:0] id,
                      input logic ordy, input bit en = 1'b1);
    bit   ov, ir, inf, outf;
    int   lim, np;
    ent_t e;
    @(negedge clk);
    rst       = r;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    ov = (q.size() > 0) && (q[0].pos == D-1);
    ir = !fl && ((q.size() < D) || ordy);
    if (en) begin
      chk("in_ready", 32'(in_ready), 32'(ir));
      chk("out_valid", 32'(out_valid), 32'(ov));
      chk("count", 32'(count), 32'(q.size()));
      chk("out_data", 32'(out_data), 32'(last_d));
    end
    @(posedge clk);
    inf  = iv && ir && !r;
    outf = ov && ordy && !r;
    if (r) begin
      q.delete();
      last_d = RV;
    end else begin
      if (outf)
        void'(q.pop_front());
      if (fl) begin
        q.delete();
      end else begin
        lim = D-1;
        foreach (q[i]) begin
          np = (q[i].pos + 1 < lim) ? q[i].pos + 1 : lim;
          if (np == D-1 && q[i].pos != D-1)
            last_d = q[i].data;
          q[i].pos = np;
          lim = np - 1;
        end
        if (inf) begin
          e.data = id;
          e.pos  = 0;
          q.push_back(e);
          if (D == 1)
            last_d = id;
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'b0, 1'b0, 8'h00, ordy);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset held two cycles with in_valid high
    step(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'hEF, 1'b1);
    idle(1, 1'b0);

    // Streaming
    for (int k = 1; k <= 8; k++)
      step(1'b0, 1'b0, 1'b1, 8'(k), 1'b1);
    idle(6, 1'b1);

    // Stall and fill
    for (int k = 'h10; k <= 'h13; k++)
      step(1'b0, 1'b0, 1'b1, 8'(k), 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h14, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h14, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h14, 1'b1);
    idle(7, 1'b1);

    // Bubble collapse
    step(1'b0, 1'b0, 1'b1, 8'h20, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h21, 1'b0);
    idle(3, 1'b0);
    idle(5, 1'b1);

    // Flush mid-stream
    step(1'b0, 1'b0, 1'b1, 8'h30, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h31, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h32, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h34, 1'b1);
    idle(6, 1'b1);

    // Reset mid-operation
    step(1'b0, 1'b0, 1'b1, 8'h40, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h41, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h42, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h43, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h44, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h45, 1'b1);
    idle(6, 1'b1);

    // Random traffic
    for (int k = 0; k < 800; k++)
      step(($urandom % 150) == 0,
           ($urandom % 60) == 0,
           ($urandom % 4) != 0,
           8'($urandom),
           ($urandom % 3) != 0);
    idle(6, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dff_pipeline.md
# dff_pipeline

Parametrised multi-stage register pipeline built from D flip-flops. Each stage holds a data word and a valid bit, with a valid/ready handshake on both ends. Stalled data stays in place and empty stages close up under back-pressure. It is the general-purpose delay and retiming element that replaces single flip-flops wherever a data path needs several cycles of registered delay with flow control, synchronous flush and a known reset value.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 4: number of register stages, ≥1.
- RESET_VAL, 0: value loaded into every stage data register on reset, WIDTH bits.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  upstream word present.
- in_ready  output  1  pipeline accepts a word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  last stage holds a word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  WIDTH  last-stage data register.
- count  output  $clog2(DEPTH+1)  number of valid stages.

## Operation
- Stage index runs from 0 (input side) to DEPTH-1 (output side). Each stage holds v[i] and d[i].
- adv[DEPTH-1] = !v[DEPTH-1] || out_ready.
- adv[i] = !v[i] || adv[i+1] for i < DEPTH-1.
- A stage loads from its predecessor when adv[i] is 1. Stage 0 loads from in_data/in_valid.
- On load, v[i] takes the predecessor's valid. d[i] loads only when that valid is 1; otherwise d[i] holds.
- A stage with adv[i]=0 holds both v and d.
- in_ready = adv[0] && !flush.
- A transfer in occurs on in_valid && in_ready. A transfer out occurs on out_valid && out_ready.
- out_valid = v[DEPTH-1]. out_data = d[DEPTH-1]. Both are direct register outputs.
- count = popcount(v). It is registered or derived from the registered v, but must equal popcount(v) every cycle.
- Flush: next edge sets all v to 0, and no word is accepted that cycle. d is left unchanged. A word presented on out_data during the flush cycle counts as transferred only if out_ready=1.
- Priority: rst > flush > normal advance.
- Reset: all v=0 and all d=RESET_VAL. Reset value of every output is in_ready=1, out_valid=0, out_data=RESET_VAL, count=0.
- Word order is strictly preserved. No word is duplicated or dropped except by flush or rst.
- While out_valid=1 && out_ready=0, out_data must remain stable.
- The out_ready→in_ready path is combinational through the adv chain. This is intentional, and the chain length is DEPTH.

## Timing
- Latency with no stall: a word accepted at edge n appears with out_valid=1 after edge n+DEPTH-1. It is consumable at edge n+DEPTH, so the latency is DEPTH cycles.
- Throughput: one word per cycle with continuous in_valid and out_ready.
- Full: count=DEPTH and out_ready=0 → in_ready=0. With out_ready=1, a simultaneous in and out is allowed and count stays at DEPTH.
- Empty: count=0 → out_valid=0 and in_ready=1, unless flush is high.
- Bubble collapse: while the output stalls, newly accepted words advance until they sit directly behind the stalled word. There is one stage per cycle of movement.
- A rst asserted mid-stream takes effect at the next edge regardless of handshake state. The first accept is possible in the cycle after rst deasserts.
- DEPTH=1 degenerates to a single registered stage with in_ready = !v[0] || out_ready.

## Test plan
All scenarios use WIDTH=8, DEPTH=4 and RESET_VAL=8'hA5.
- Reset: hold rst for 2 cycles with in_valid=1 → out_valid=0, out_data=8'hA5, count=0, in_ready=1; no word accepted.
- Streaming: send 8'h01..8'h08 on consecutive cycles with out_ready=1 → 8'h01 is valid 3 edges after its acceptance edge, then outputs run 01..08 on consecutive cycles with no gaps.
- Stall and fill: out_ready=0, send 10,11,12,13,14 → first four accepted, in_ready=0 after count=4, 14 held upstream; raise out_ready → output 10,11,12,13,14 in order, with count showing 4,4,4,3,... as expected.
- Bubble collapse: send 20, idle 3 cycles, send 21 with out_ready=0 → 21 reaches stage 2 and count=2; release → 20 then 21 on back-to-back cycles.
- Flush mid-stream: load 30,31,32, assert flush one cycle with in_valid=1 and in_data=33 → count=0, out_valid=0 next cycle, 33 not accepted; next word 34 emerges alone.
- Reset mid-operation: with count=3 and stalled, pulse rst → next cycle count=0 and out_data=8'hA5; subsequent traffic flows normally.
